// File: rtl/voq_pkg.sv
// ---------------------------------------------------------------------------
// voq_pkg
// Shared defaults and helpers for the virtual-output-queue controller.
//   DEF_PACKET_CNT / DEF_EGRESS_CNT / DEF_META_WIDTH : default parameters
//   DROP_CNT_W                                      : drop counter width
//   lane_lsb()                                      : LSB of lane idx in a
//                                                     flattened per-VOQ bus
// ---------------------------------------------------------------------------
package voq_pkg;

  localparam int DEF_PACKET_CNT = 1024;
  localparam int DEF_EGRESS_CNT = 4;
  localparam int DEF_META_WIDTH = 10;
  localparam int DROP_CNT_W     = 16;

  // Per-VOQ buses (occupancy, drop_cnt) are flattened with VOQ i occupying
  // bits [lane_lsb(i, w) +: w].
  function automatic int lane_lsb(input int idx, input int lane_w);
    return idx * lane_w;
  endfunction

endpackage : voq_pkg

// File: rtl/simple_dual_port_mem.sv
// ---------------------------------------------------------------------------
// simple_dual_port_mem
// One write port, one read port, registered read data (1-cycle latency).
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates the following cycle
//   rd_addr  : read address
//   rd_data  : registered read data (holds when rd_en=0)
// ---------------------------------------------------------------------------
module simple_dual_port_mem #(
  parameter int  MEM_SIZE   = 1024,
  parameter int  DATA_WIDTH = 10,
  localparam int ADDR_W     = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // NOTE: the array has no reset so it maps onto block RAM; every reader of
  // rd_data qualifies it with its own reset-cleared valid flag.
  // NOTE: sequential state is updated with <= so all registers sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule : simple_dual_port_mem

// File: rtl/voq_ptr.sv
// ---------------------------------------------------------------------------
// voq_ptr
// Pointer pair, flags and occupancy for one VOQ ring buffer.
//   clk, rst_n : clock, async active-low reset
//   enq_acc    : accepted enqueue this cycle (wr advances)
//   deq_acc    : accepted dequeue this cycle (rd advances)
//   flush      : rd <- wr (takes precedence over deq_acc)
//   wr_addr    : wr pointer without wrap bit (ring slot)
//   rd_addr    : rd pointer without wrap bit (ring slot)
//   occ        : wr - rd, modulo 2^(PTR_W+1)
//   empty/full : occ == 0 / occ == PACKET_CNT
// ---------------------------------------------------------------------------
module voq_ptr
  import voq_pkg::*;
#(
  parameter int  PACKET_CNT = DEF_PACKET_CNT,
  localparam int PTR_W      = $clog2(PACKET_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_acc,
  input  logic             deq_acc,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] rd_addr,
  output logic [PTR_W:0]   occ,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(PACKET_CNT);

  // The extra MSB is a wrap bit, so full (PACKET_CNT) and empty (0) are
  // distinguishable and every slot is usable.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_acc) wr_ptr <= wr_ptr + 1'b1;
      // The top blocks enqueue on a flushed VOQ, so wr_ptr here is final.
      if (flush)        rd_ptr <= wr_ptr;
      else if (deq_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign wr_addr = wr_ptr[PTR_W-1:0];
  assign rd_addr = rd_ptr[PTR_W-1:0];
  assign occ     = wr_ptr - rd_ptr;
  assign empty   = (occ == '0);
  assign full    = (occ == OCC_FULL);

endmodule : voq_ptr

// File: rtl/voq_ctrl.sv
// ---------------------------------------------------------------------------
// voq_ctrl
// Virtual-output-queue controller for one ingress port: EGRESS_CNT ring
// buffers of packet metadata sharing one simple dual-port memory, addressed
// as {voq, slot}.
//
// Optional feature macro: VOQ_CTRL_DROP_CNT_EN
//   defined   : per-VOQ 16-bit saturating drop counters on drop_cnt
//   undefined : drop_cnt tied to 0
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   enq_en/sel/meta       : enqueue request, target VOQ, metadata
//   enq_drop              : registered pulse, previous enqueue refused
//   deq_en/sel            : dequeue request, source VOQ
//   deq_valid/meta/qid    : dequeue result, one cycle after acceptance
//   flush_en/sel          : empty one VOQ (rd <- wr)
//   is_empty/is_full      : per-VOQ flags from registered pointers
//   occupancy             : per-VOQ entry count, PTR_W+1 bits per lane
//   drop_cnt              : per-VOQ drop counters, 16 bits per lane
// ---------------------------------------------------------------------------
module voq_ctrl
  import voq_pkg::*;
#(
  parameter int  PACKET_CNT = DEF_PACKET_CNT,
  parameter int  EGRESS_CNT = DEF_EGRESS_CNT,
  parameter int  META_WIDTH = DEF_META_WIDTH,
  localparam int SEL_W      = $clog2(EGRESS_CNT),
  localparam int PTR_W      = $clog2(PACKET_CNT),
  localparam int OCC_W      = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enq_en,
  input  logic [SEL_W-1:0]                 enq_sel,
  input  logic [META_WIDTH-1:0]            enq_meta,
  output logic                             enq_drop,
  input  logic                             deq_en,
  input  logic [SEL_W-1:0]                 deq_sel,
  output logic                             deq_valid,
  output logic [META_WIDTH-1:0]            deq_meta,
  output logic [SEL_W-1:0]                 deq_qid,
  input  logic                             flush_en,
  input  logic [SEL_W-1:0]                 flush_sel,
  output logic [EGRESS_CNT-1:0]            is_empty,
  output logic [EGRESS_CNT-1:0]            is_full,
  output logic [EGRESS_CNT*OCC_W-1:0]      occupancy,
  output logic [EGRESS_CNT*DROP_CNT_W-1:0] drop_cnt
);

  localparam int MEM_SIZE = PACKET_CNT * EGRESS_CNT;

  logic [PTR_W-1:0]      wr_addr_q [EGRESS_CNT];
  logic [PTR_W-1:0]      rd_addr_q [EGRESS_CNT];
  logic                  enq_acc;
  logic                  deq_acc;
  logic                  enq_refused;
  logic [META_WIDTH-1:0] rd_data;

  // Acceptance uses flags from registered state only, so a same-cycle
  // enq/deq on an empty VOQ never needs a read-during-write bypass.
  assign enq_acc     = enq_en && !is_full[enq_sel]
                       && !(flush_en && (flush_sel == enq_sel));
  assign deq_acc     = deq_en && !is_empty[deq_sel]
                       && !(flush_en && (flush_sel == deq_sel));
  assign enq_refused = enq_en && !enq_acc;

  for (genvar i = 0; i < EGRESS_CNT; i++) begin : g_voq
    voq_ptr #(
      .PACKET_CNT (PACKET_CNT)
    ) u_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .enq_acc (enq_acc && (enq_sel == SEL_W'(i))),
      .deq_acc (deq_acc && (deq_sel == SEL_W'(i))),
      .flush   (flush_en && (flush_sel == SEL_W'(i))),
      .wr_addr (wr_addr_q[i]),
      .rd_addr (rd_addr_q[i]),
      .occ     (occupancy[lane_lsb(i, OCC_W) +: OCC_W]),
      .empty   (is_empty[i]),
      .full    (is_full[i])
    );
  end

  simple_dual_port_mem #(
    .MEM_SIZE   (MEM_SIZE),
    .DATA_WIDTH (META_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq_acc),
    .wr_addr ({enq_sel, wr_addr_q[enq_sel]}),
    .wr_data (enq_meta),
    .rd_en   (deq_acc),
    .rd_addr ({deq_sel, rd_addr_q[deq_sel]}),
    .rd_data (rd_data)
  );

  // One-stage read pipeline. Reset clears deq_valid, which discards any
  // read that was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_drop  <= 1'b0;
      deq_valid <= 1'b0;
      deq_qid   <= '0;
    end else begin
      enq_drop  <= enq_refused;
      deq_valid <= deq_acc;
      if (deq_acc) deq_qid <= deq_sel;
    end
  end

  // rd_data holds stale or undefined contents when no read was accepted.
  assign deq_meta = deq_valid ? rd_data : '0;

`ifdef VOQ_CTRL_DROP_CNT_EN
  for (genvar i = 0; i < EGRESS_CNT; i++) begin : g_drop
    logic [DROP_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (enq_refused && (enq_sel == SEL_W'(i)) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign drop_cnt[lane_lsb(i, DROP_CNT_W) +: DROP_CNT_W] = cnt;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule : voq_ctrl

// File: tb/tb_voq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_voq_ctrl
// Self-checking bench for voq_ctrl (PACKET_CNT=8, EGRESS_CNT=4). A reference
// model of per-VOQ FIFOs (SV queues) predicts every output each cycle.
// Honours VOQ_CTRL_DROP_CNT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_voq_ctrl;

  localparam int P     = 8;
  localparam int E     = 4;
  localparam int MW    = 10;
  localparam int SEL_W = 2;
  localparam int OCC_W = 4;
  localparam int DCW   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enq_en;
  logic [SEL_W-1:0]     enq_sel;
  logic [MW-1:0]        enq_meta;
  logic                 enq_drop;
  logic                 deq_en;
  logic [SEL_W-1:0]     deq_sel;
  logic                 deq_valid;
  logic [MW-1:0]        deq_meta;
  logic [SEL_W-1:0]     deq_qid;
  logic                 flush_en;
  logic [SEL_W-1:0]     flush_sel;
  logic [E-1:0]         is_empty;
  logic [E-1:0]         is_full;
  logic [E*OCC_W-1:0]   occupancy;
  logic [E*DCW-1:0]     drop_cnt;

  voq_ctrl #(
    .PACKET_CNT (P),
    .EGRESS_CNT (E),
    .META_WIDTH (MW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_en    (enq_en),
    .enq_sel   (enq_sel),
    .enq_meta  (enq_meta),
    .enq_drop  (enq_drop),
    .deq_en    (deq_en),
    .deq_sel   (deq_sel),
    .deq_valid (deq_valid),
    .deq_meta  (deq_meta),
    .deq_qid   (deq_qid),
    .flush_en  (flush_en),
    .flush_sel (flush_sel),
    .is_empty  (is_empty),
    .is_full   (is_full),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [MW-1:0] mq [E][$];
  int            mdrop [E];
  logic          exp_valid;
  logic [MW-1:0] exp_meta;
  logic [SEL_W-1:0] exp_qid;
  logic          exp_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < E; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
    end
    exp_valid = 1'b0;
    exp_meta  = '0;
    exp_qid   = '0;
    exp_drop  = 1'b0;
  endtask

  task automatic check_state();
    check("deq_valid", 32'(deq_valid), 32'(exp_valid));
    check("deq_meta",  32'(deq_meta),  32'(exp_meta));
    check("deq_qid",   32'(deq_qid),   32'(exp_qid));
    check("enq_drop",  32'(enq_drop),  32'(exp_drop));
    for (int i = 0; i < E; i++) begin
      check($sformatf("occupancy[%0d]", i), 32'(occupancy[i*OCC_W +: OCC_W]), mq[i].size());
      check($sformatf("is_empty[%0d]", i), 32'(is_empty[i]), 32'(mq[i].size() == 0));
      check($sformatf("is_full[%0d]", i),  32'(is_full[i]),  32'(mq[i].size() == P));
`ifdef VOQ_CTRL_DROP_CNT_EN
      check($sformatf("drop_cnt[%0d]", i), 32'(drop_cnt[i*DCW +: DCW]), 32'(mdrop[i]));
`else
      check($sformatf("drop_cnt[%0d]", i), 32'(drop_cnt[i*DCW +: DCW]), 32'd0);
`endif
    end
  endtask

  // One clock cycle of stimulus: the model decides from the queue contents
  // before the edge, the DUT outputs are checked 1 time unit after it.
  task automatic step(input logic ee, input int es, input logic [MW-1:0] em,
                      input logic de, input int ds, input logic fe, input int fs);
    logic enq_ok;
    logic deq_ok;
    enq_ok = ee && (mq[es].size() < P) && !(fe && fs == es);
    deq_ok = de && (mq[ds].size() > 0) && !(fe && fs == ds);
    exp_valid = deq_ok;
    exp_meta  = '0;
    if (deq_ok) begin
      exp_meta = mq[ds].pop_front();
      exp_qid  = SEL_W'(ds);
    end
    if (fe) mq[fs].delete();
    if (enq_ok) mq[es].push_back(em);
    exp_drop = ee && !enq_ok;
    if (exp_drop && mdrop[es] < 16'hFFFF) mdrop[es]++;

    enq_en    = ee;
    enq_sel   = SEL_W'(es);
    enq_meta  = em;
    deq_en    = de;
    deq_sel   = SEL_W'(ds);
    flush_en  = fe;
    flush_sel = SEL_W'(fs);
    @(posedge clk);
    #1;
    enq_en   = 1'b0;
    deq_en   = 1'b0;
    flush_en = 1'b0;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    enq_en    = 1'b0;
    enq_sel   = '0;
    enq_meta  = '0;
    deq_en    = 1'b0;
    deq_sel   = '0;
    flush_en  = 1'b0;
    flush_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();

    // FIFO order on VOQ2
    step(1, 2, 10'd5, 0, 0, 0, 0);
    step(1, 2, 10'd6, 0, 0, 0, 0);
    step(1, 2, 10'd7, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, '0, 1, 2, 0, 0);
    idle();

    // Fill VOQ1, overflow once, drain
    for (int k = 0; k < P; k++) step(1, 1, MW'(10'h100 + k), 0, 0, 0, 0);
    step(1, 1, 10'h3FF, 0, 0, 0, 0);
    for (int k = 0; k < P; k++) step(0, 0, '0, 1, 1, 0, 0);
    idle();

    // Wrap-around on VOQ0 with simultaneous enq/deq
    for (int k = 0; k < 3 * P; k++) begin
      step(1, 0, MW'(k + 1), 1, 0, 0, 0);
      check("wrap_occ_le1", 32'(occupancy[0 +: OCC_W] <= 1), 32'd1);
    end
    step(0, 0, '0, 1, 0, 0, 0);

    // Same-cycle enq/deq on an empty VOQ3
    step(1, 3, 10'd9, 1, 3, 0, 0);
    step(0, 0, '0, 1, 3, 0, 0);

    // Flush VOQ0 holding 4 entries while an enqueue targets it
    for (int k = 0; k < 4; k++) step(1, 0, MW'(10'h20 + k), 0, 0, 0, 0);
    step(1, 0, 10'h55, 0, 0, 1, 0);
    step(1, 0, 10'h3A, 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, E - 1)), MW'($urandom()),
           1'($urandom_range(0, 99) < 50), int'($urandom_range(0, E - 1)),
           1'($urandom_range(0, 99) < 4),  int'($urandom_range(0, E - 1)));
    end

    // Reset with a dequeue result pending and another read in flight
    step(1, 1, 10'h11, 0, 0, 0, 0);
    step(1, 2, 10'h22, 0, 0, 0, 0);
    step(1, 2, 10'h23, 1, 1, 0, 0);
    deq_en  = 1'b1;
    deq_sel = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    deq_en = 1'b0;
    check_state();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_voq_ctrl
